// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-slot TDM demultiplexer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int SLOTS  = 4;
    localparam int SLOT_W = 2;
    localparam int MISS_W = 3;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Modulo-4 slot counter with synchronous load and increment enable.
// Latency: cnt reflects load/inc on the clock edge after they are asserted.
// Backpressure: none; holds its value whenever neither load nor inc is set.
//
// Ports: clk, rst_n (sync, active-low); load/load_val force a value (load wins
// over inc); inc advances by one and wraps 3 -> 0; cnt is the current slot.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [SLOT_W-1:0] load_val,
    input  logic              inc,
    output logic [SLOT_W-1:0] cnt
);

    logic [SLOT_W-1:0] cnt_q;
    logic [SLOT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (inc) begin
            // SLOT_W bits wide, so 3 + 1 wraps to 0 on its own
            cnt_d = cnt_q + SLOT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/tdm_demux4.sv
// Serial TDM demux: gathers 4 slots per frame (sync marks slot 0) into q.
// Latency: q/q_valid appear 1 cycle after the edge accepting the slot-3 beat.
// Backpressure: none; din_valid low stalls the frame, gaps of any length are fine.
//
// Ports: clk, rst_n (sync, active-low); din/din_valid/sync serial input;
// q/q_valid completed frame + 1-cycle pulse; slot = next slot written;
// locked = frame alignment held; sync_err = 1-cycle pulse on a sync violation.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int unsigned MISS_LIMIT = 2,
    parameter bit          SYNC_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    input  logic              din_valid,
    input  logic              sync,
    output logic [SLOTS-1:0]  q,
    output logic              q_valid,
    output logic [SLOT_W-1:0] slot,
    output logic              locked,
    output logic              sync_err
);

    localparam logic [MISS_W:0] MISS_LIM = (MISS_W+1)'(MISS_LIMIT);

    state_t             state_q,    state_d;
    logic [SLOTS-2:0]   shadow_q,   shadow_d;
    logic [MISS_W-1:0]  miss_q,     miss_d;
    logic [SLOTS-1:0]   q_q,        q_d;
    logic               q_valid_q,  q_valid_d;
    logic               sync_err_q, sync_err_d;

    logic               slot_load;
    logic [SLOT_W-1:0]  slot_load_val;
    logic               slot_inc;
    logic [SLOT_W-1:0]  slot_cur;
    logic [MISS_W:0]    miss_inc;

    tdm_slot_ctr u_slot_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (slot_load),
        .load_val (slot_load_val),
        .inc      (slot_inc),
        .cnt      (slot_cur)
    );

    // One bit wider than the counter so the limit compare never wraps.
    assign miss_inc = (MISS_W+1)'(miss_q) + (MISS_W+1)'(1);

    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        miss_d        = miss_q;
        q_d           = q_q;
        q_valid_d     = 1'b0;
        sync_err_d    = 1'b0;
        slot_load     = 1'b0;
        slot_load_val = '0;
        slot_inc      = 1'b0;

        if (din_valid) begin
            unique case (state_q)
                HUNT: begin
                    // Only a sync beat can start a frame; everything else is dropped.
                    if (sync) begin
                        shadow_d[0]   = din;
                        slot_load     = 1'b1;
                        slot_load_val = SLOT_W'(1);
                        miss_d        = '0;
                        state_d       = LOCKED;
                    end
                end

                LOCKED: begin
                    if (sync && (slot_cur != '0)) begin
                        // Early sync: realign on this beat, partial frame is lost.
                        sync_err_d    = 1'b1;
                        shadow_d[0]   = din;
                        slot_load     = 1'b1;
                        slot_load_val = SLOT_W'(1);
                        miss_d        = '0;
                    end else if (slot_cur == '0) begin
                        if (sync) begin
                            shadow_d[0] = din;
                            miss_d      = '0;
                            slot_inc    = 1'b1;
                        end else if (SYNC_CHECK) begin
                            sync_err_d = 1'b1;
                            miss_d     = miss_inc[MISS_W-1:0];
                            if (miss_inc >= MISS_LIM) begin
                                // Too many misses: give up alignment, drop this beat.
                                state_d       = HUNT;
                                slot_load     = 1'b1;
                                slot_load_val = '0;
                            end else begin
                                shadow_d[0] = din;
                                slot_inc    = 1'b1;
                            end
                        end else begin
                            // Flywheel: missing sync is tolerated silently.
                            shadow_d[0] = din;
                            slot_inc    = 1'b1;
                        end
                    end else if (slot_cur == SLOT_W'(SLOTS-1)) begin
                        // Last slot goes straight into q; no need to shadow it.
                        q_d       = {din, shadow_q};
                        q_valid_d = 1'b1;
                        slot_inc  = 1'b1;
                    end else begin
                        shadow_d[slot_cur] = din;
                        slot_inc           = 1'b1;
                    end
                end

                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            shadow_q   <= '0;
            miss_q     <= '0;
            q_q        <= '0;
            q_valid_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            miss_q     <= miss_d;
            q_q        <= q_d;
            q_valid_q  <= q_valid_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign q        = q_q;
    assign q_valid  = q_valid_q;
    assign slot     = slot_cur;
    assign locked   = (state_q == LOCKED);
    assign sync_err = sync_err_q;

endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 Parameter MISS_LIMIT, default 2: consecutive frames whose slot-0 beat arrives without sync before lock is dropped; legal range 1..7.
REQ-002 Parameter SYNC_CHECK, default 1: 1 = enforce sync at slot 0; 0 = flywheel, never drop lock on a missing sync.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 din  input  1  time-multiplexed serial data, one slot per accepted beat.
REQ-006 din_valid  input  1  beat qualifier; din and sync are sampled only when high.
REQ-007 sync  input  1  marks the beat carrying slot 0 of a frame.
REQ-008 q  output  4  last complete frame; q[i] = data from slot i.
REQ-009 q_valid  output  1  one-cycle pulse, q updated this cycle.
REQ-010 slot  output  2  slot index the next accepted beat is written to.
REQ-011 locked  output  1  high in state LOCKED.
REQ-012 sync_err  output  1  one-cycle pulse on any sync violation.

Function
REQ-013 Two states: HUNT and LOCKED.
REQ-014 In HUNT, beats without sync are discarded, and slot stays 0.
REQ-015 In HUNT, a beat with sync high writes din to shadow[0], sets slot=1, clears the miss counter, and moves to LOCKED.
REQ-016 In LOCKED, each beat writes din to shadow[slot], and slot increments modulo 4 (3 wraps to 0).
REQ-017 When the slot-3 beat is accepted, q loads {din, shadow[2:0]} on that clock edge, and q_valid is high for exactly the following cycle.
REQ-018 Latency from the slot-3 beat edge to q/q_valid visible: 1 cycle.
REQ-019 q holds its value until the next complete frame.
REQ-020 Cycles with din_valid low change nothing; gaps of any length inside a frame are legal.
REQ-021 Early sync: in LOCKED, sync high with slot != 0 produces the following in one cycle:
- sync_err pulses.
- the partial frame is discarded, with no q_valid.
- din is written to shadow[0], and slot is set to 1.
- the miss counter is cleared.
REQ-022 Missing sync with SYNC_CHECK=1: in LOCKED, slot 0 accepted with sync low produces the following in one cycle:
- sync_err pulses.
- the miss counter increments.
- the beat is stored normally.
REQ-023 When the miss counter reaches MISS_LIMIT, the state moves to HUNT in the same cycle, slot is set to 0, and the beat is discarded.
REQ-024 A slot-0 beat with sync high clears the miss counter.
REQ-025 Missing sync with SYNC_CHECK=0: a slot-0 beat without sync is accepted silently, with no sync_err and no counting.
REQ-026 A frame completing in LOCKED always produces q_valid, even if errors occurred in earlier frames.

Reset
REQ-027 While rst_n is low on a clock edge, the block clears:
- state to HUNT.
- slot, shadow, and miss counter to 0.
- q to 4'b0000, and q_valid, locked, and sync_err to 0.
REQ-028 Reset mid-frame discards the partial frame, and no q_valid follows reset release.
REQ-029 The first accepted beat after reset release is processed per REQ-014/015.

Structure
REQ-030 Shared package tdm_pkg holds:
- the state enum (HUNT, LOCKED).
- constant SLOTS=4 and SLOT_W=2.
- the miss counter width constant (3).
REQ-031 One sub-module, tdm_slot_ctr, holds the modulo-4 slot counter with load and increment enable.

Verification
REQ-032 Reset, then sync+din=1, then din=0,1,1 on consecutive beats -> q=4'b1101 and q_valid pulses 1 cycle after the 4th beat, with locked=1.
REQ-033 Locked; frame 1,0,0,1 with din_valid low for 3 cycles between slots 1 and 2 -> q=4'b1001, q_valid exactly once, and slot holds during the gap.
REQ-034 Locked, slot=2; sync arrives with din=1 -> sync_err pulses, no q_valid, slot=1, and the next 3 beats 0,0,0 give q=4'b0001.
REQ-035 SYNC_CHECK=1, MISS_LIMIT=2; two consecutive frames with no sync at slot 0 -> sync_err on both, and locked drops to 0 at the second slot-0 beat.
REQ-036 SYNC_CHECK=0; same stimulus -> no sync_err, locked stays 1, and q_valid occurs every frame.
REQ-037 rst_n low for 1 cycle at slot=2, then released -> all outputs 0, no q_valid, and beats ignored until sync.
